ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Single-port RAM arbiter that shares the one RAM between all cache requesters: the icache and dcache of each core.
- Accepts independent read/write requests.
- Grants exactly one requester at a time, round-robin.
- Drives the RAM bus and returns per-requester wait/data, in the same handshake style the caches already use (wait held high until data is valid).

Parameters:
NREQ, 4, number of requesters (core0 I, core0 D, core1 I, core1 D); minimum 2
ADDR_W, 32, address width
DATA_W, 32, data word width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
req_ren  in  NREQ  per-requester read request
req_wen  in  NREQ  per-requester write request
req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  packed write data
req_wait  out  NREQ  1 = requester must hold request; 0 = access completed this cycle
req_rdata  out  DATA_W  shared read data, valid when the owning req_wait bit is 0
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
ram_state  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Registered state: fsm (IDLE, BUSY), grant index g (clog2(NREQ) bits), last index lg.
- Reset (async, any time, including mid-access): fsm=IDLE, g=0, lg=NREQ-1, so requester 0 has first priority.
- Outputs during reset and IDLE: ram_ren=0, ram_wen=0, ram_addr=0, ram_wdata=0, req_rdata=0.
- Active request: act[i] = req_ren[i] | req_wen[i].
- IDLE:
  - If any act bit is set, select the first active index scanning lg+1, lg+2, ... modulo NREQ.
  - Load g with that index; fsm -> BUSY.
  - No act bit set: stay in IDLE.
- BUSY, RAM drive (combinational from g):
  - ram_addr = req_addr[g]; ram_wdata = req_wdata[g].
  - ram_wen = req_wen[g]; ram_ren = req_ren[g] & ~req_wen[g] (write wins if both are set).
- BUSY, ram_state==ACCESS:
  - req_wait[g]=0 this cycle; req_rdata = ram_rdata.
  - Next edge: lg <= g, fsm -> IDLE.
- BUSY, ram_state==ERROR: fsm -> IDLE; req_wait[g] stays 1; lg unchanged, so the same requester is retried first.
- BUSY, ram_state FREE or BUSY: hold all state.
- BUSY, act[g] drops before ACCESS (flush/abort): RAM strobes go 0 that cycle; fsm -> IDLE; lg unchanged; no completion reported.
- req_wait[i] = act[i] & ~(fsm==BUSY & g==i & ram_state==ACCESS). An idle requester sees wait=0.
- Latency: request sampled in IDLE at edge N; RAM strobes asserted from cycle N+1; completion in the ACCESS cycle.
- One mandatory IDLE bubble between consecutive grants (without the optional feature).
- Fairness: every active requester is granted within NREQ grants.
- Requests arriving during BUSY are only evaluated in IDLE.
- req_* changes other than to act[g] are ignored during BUSY, except address/data of g, which pass through combinationally.

Optional Feature:
Macro ARB_LOCK_EN.
- Defined:
  - Adds input req_lock (NREQ).
  - On ACCESS completion, if req_lock[g]=1, fsm stays BUSY with the same g and lg is not updated (back-to-back, no bubble).
  - Used for atomic LL/SC sequences and block fills.
  - Lock drops, or act[g] falls: normal IDLE path.
  - ERROR releases the lock path (goes IDLE).
- Undefined: no req_lock port; always returns to IDLE after completion.

Test Plan:
- Reset then single read: req_ren[2]=1, addr 0x100, RAM gives ACCESS after 3 BUSY cycles with rdata 0xDEADBEEF -> ram_ren=1, ram_addr=0x100 from cycle 1; req_wait[2]=0 and req_rdata=0xDEADBEEF exactly in the ACCESS cycle; fsm returns to IDLE.
- All 4 requesters reading continuously, RAM ACCESS immediately -> grant order 0,1,2,3,0,1 with one IDLE cycle between grants.
- req_ren[1]=req_wen[1]=1, wdata 0x12345678 -> ram_wen=1, ram_ren=0, ram_wdata=0x12345678.
- Requester 3 granted, ram_state=ERROR -> fsm IDLE, req_wait[3] held 1, requester 3 re-granted next even with requester 0 active.
- Requester 0 drops req_ren mid-BUSY -> strobes 0 the same cycle; next grant goes to another active requester; RST asserted during BUSY -> outputs 0 immediately, g=0, lg=3.
- ARB_LOCK_EN: requester 1 with req_lock=1 does 2 reads while requester 2 is active -> both reads to 1 back-to-back with no IDLE; then lock=0 -> requester 2 granted next.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Round-robin arbiter that shares one single-port RAM between several
// cache requesters (icache/dcache of each core). One requester owns the
// RAM bus at a time. Its req_wait bit stays high until the cycle in which
// the RAM reports ACCESS.
//
// Ports:
//   CLK, RST    clock (rising edge) and asynchronous active-high reset
//   req_ren     per-requester read request
//   req_wen     per-requester write request
//   req_addr    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata   packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_wait    1 = hold the request, 0 = access completed this cycle
//   req_rdata   shared read data, valid while the owner's req_wait is 0
//   ram_ren     RAM read strobe
//   ram_wen     RAM write strobe
//   ram_addr    RAM address
//   ram_wdata   RAM write data
//   ram_rdata   RAM read data
//   ram_state   RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   req_lock    (ARB_LOCK_EN only) keeps the grant across completions
//
// Optional feature macro: ARB_LOCK_EN. When it is defined, a locked
// requester is served back-to-back without the IDLE bubble.
module ram_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_wait,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     ram_ren,
  output logic                     ram_wen,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  input  logic [1:0]               ram_state
`ifdef ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]          req_lock
`endif
);

  localparam int GW = $clog2(NREQ);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {IDLE, BUSY} fsm_t;

  fsm_t            fsm, fsm_next;
  logic [GW-1:0]   g, g_next;
  logic [GW-1:0]   lg, lg_next;
  logic [NREQ-1:0] act;
  logic [NREQ-1:0] done_vec;
  logic [GW-1:0]   pick;
  logic            found;
  logic            done;
  int              idx_int;
  logic [GW-1:0]   idx;

  assign act = req_ren | req_wen;

  // The requester after the last served one has top priority. Walk
  // forward from lg+1 and wrap modulo NREQ; the first active index wins.
  // NREQ may not be a power of two, so the wrap uses an integer modulo.
  always_comb begin
    pick    = '0;
    found   = 1'b0;
    idx_int = 0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_int = (int'(lg) + k) % NREQ;
      idx     = GW'(idx_int);
      if (!found && act[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state logic and RAM bus drive.
  // Everything is 0 in IDLE. In BUSY, the owner's address and data pass
  // straight through. The strobes drop as soon as the owner withdraws its
  // request. A write wins over a read when both are raised. lg advances
  // only on a completed, unlocked access. This means an error or an abort
  // leaves the same requester first in line.
  always_comb begin
    fsm_next  = fsm;
    g_next    = g;
    lg_next   = lg;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    req_rdata = '0;
    done      = 1'b0;
    case (fsm)
      IDLE: begin
        if (found) begin
          g_next   = pick;
          fsm_next = BUSY;
        end
      end
      BUSY: begin
        ram_addr  = req_addr[int'(g)*ADDR_W +: ADDR_W];
        ram_wdata = req_wdata[int'(g)*DATA_W +: DATA_W];
        if (!act[g]) begin
          fsm_next = IDLE;
        end else begin
          ram_wen = req_wen[g];
          ram_ren = req_ren[g] & ~req_wen[g];
          if (ram_state == RS_ACCESS) begin
            done      = 1'b1;
            req_rdata = ram_rdata;
`ifdef ARB_LOCK_EN
            if (!req_lock[g]) begin
              lg_next  = g;
              fsm_next = IDLE;
            end
`else
            lg_next  = g;
            fsm_next = IDLE;
`endif
          end else if (ram_state == RS_ERROR) begin
            fsm_next = IDLE;
          end
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // A requester waits whenever it is active. The only exception is the
  // owner during its ACCESS cycle. A requester with no request sees 0.
  always_comb begin
    done_vec    = '0;
    done_vec[g] = done;
    req_wait    = act & ~done_vec;
  end

  // State register. Reset makes requester 0 first in line by pretending
  // the last grant went to NREQ-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm <= IDLE;
      g   <= '0;
      lg  <= GW'(NREQ - 1);
    end else begin
      fsm <= fsm_next;
      g   <= g_next;
      lg  <= lg_next;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with the default 4 requesters and
// 32-bit address and data. Stimulus changes 1 time unit after a rising
// edge. Outputs are sampled 1 unit later, well before the next edge.
module tb_ram_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic         CLK;
  logic         RST;
  logic [3:0]   req_ren;
  logic [3:0]   req_wen;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_wait;
  logic [31:0]  req_rdata;
  logic         ram_ren;
  logic         ram_wen;
  logic [31:0]  ram_addr;
  logic [31:0]  ram_wdata;
  logic [31:0]  ram_rdata;
  logic [1:0]   ram_state;
`ifdef ARB_LOCK_EN
  logic [3:0]   req_lock;
`endif

  int errors;
  int checks;

  ram_arbiter #(.NREQ(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK),
    .RST(RST),
    .req_ren(req_ren),
    .req_wen(req_wen),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wait(req_wait),
    .req_rdata(req_rdata),
    .ram_ren(ram_ren),
    .ram_wen(ram_wen),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .ram_state(ram_state)
`ifdef ARB_LOCK_EN
    ,
    .req_lock(req_lock)
`endif
  );

  // 10-unit clock period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST       = 1'b1;
    req_ren   = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_wdata = '0;
    ram_state = FREE;
    ram_rdata = '0;
`ifdef ARB_LOCK_EN
    req_lock  = '0;
`endif
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST       = 1'b1;
    req_ren   = 4'hF;
    req_wen   = 4'h0;
    req_addr  = {4{32'hCAFE0000}};
    req_wdata = {4{32'h55AA55AA}};
    ram_state = ACCESS;
    ram_rdata = 32'hFFFF0000;
`ifdef ARB_LOCK_EN
    req_lock  = '0;
`endif
    #1;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL rst_ren: got %0b want 0", ram_ren); end
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL rst_wen: got %0b want 0", ram_wen); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h want 0", ram_addr); end
    checks++; if (ram_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_wdata: got %h want 0", ram_wdata); end
    checks++; if (req_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h want 0", req_rdata); end
    checks++; if (req_wait !== 4'hF) begin errors++; $display("[TB] FAIL rst_wait: got %b want 1111", req_wait); end
    next_cycle;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL rst_hold_ren: got %0b want 0", ram_ren); end
  endtask

  task automatic test_single_read;
    do_reset;
    req_ren[2]          = 1'b1;
    req_addr[64 +: 32]  = 32'h100;
    ram_rdata           = 32'hDEADBEEF;
    #1;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL rd_idle_ren: got %0b want 0", ram_ren); end
    checks++; if (req_wait !== 4'b0100) begin errors++; $display("[TB] FAIL rd_idle_wait: got %b want 0100", req_wait); end
    for (int b = 0; b < 4; b++) begin
      next_cycle;
      ram_state = (b == 3) ? ACCESS : BUSY;
      #1;
      checks++; if (ram_ren !== 1'b1) begin errors++; $display("[TB] FAIL rd_ren[%0d]: got %0b want 1", b, ram_ren); end
      checks++; if (ram_addr !== 32'h100) begin errors++; $display("[TB] FAIL rd_addr[%0d]: got %h want 100", b, ram_addr); end
      checks++; if (req_wait[2] !== (b != 3)) begin errors++; $display("[TB] FAIL rd_wait[%0d]: got %0b want %0b", b, req_wait[2], (b != 3)); end
    end
    checks++; if (req_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_data: got %h want deadbeef", req_rdata); end
    next_cycle;
    ram_state = FREE;
    #1;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL rd_back_idle: got %0b want 0", ram_ren); end
    checks++; if (req_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rd_idle_rdata: got %h want 0", req_rdata); end
    checks++; if (req_wait !== 4'b0100) begin errors++; $display("[TB] FAIL rd_after_wait: got %b want 0100", req_wait); end
    req_ren = '0;
  endtask

  task automatic test_round_robin;
    int exp_idx;
    do_reset;
    ram_state = ACCESS;
    req_ren   = 4'hF;
    for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h1000 + 32'(i * 16);
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_idx = k % 4;
      checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL rr_bubble[%0d]: got %0b want 0", k, ram_ren); end
      next_cycle;
      checks++; if (ram_addr !== 32'h1000 + 32'(exp_idx * 16)) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %h want %h", k, ram_addr, 32'h1000 + 32'(exp_idx * 16)); end
      checks++; if (req_wait !== (4'hF & ~(4'b0001 << exp_idx))) begin errors++; $display("[TB] FAIL rr_wait[%0d]: got %b want %b", k, req_wait, (4'hF & ~(4'b0001 << exp_idx))); end
      next_cycle;
    end
    req_ren = '0;
  endtask

  task automatic test_write_wins;
    do_reset;
    req_ren[1]          = 1'b1;
    req_wen[1]          = 1'b1;
    req_addr[32 +: 32]  = 32'h200;
    req_wdata[32 +: 32] = 32'h12345678;
    #1;
    next_cycle;
    checks++; if (ram_wen !== 1'b1) begin errors++; $display("[TB] FAIL wr_wen: got %0b want 1", ram_wen); end
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL wr_ren: got %0b want 0", ram_ren); end
    checks++; if (ram_wdata !== 32'h12345678) begin errors++; $display("[TB] FAIL wr_wdata: got %h want 12345678", ram_wdata); end
    checks++; if (ram_addr !== 32'h200) begin errors++; $display("[TB] FAIL wr_addr: got %h want 200", ram_addr); end
    ram_state = ACCESS;
    #1;
    checks++; if (req_wait !== 4'b0000) begin errors++; $display("[TB] FAIL wr_done: got %b want 0000", req_wait); end
    next_cycle;
    req_ren   = '0;
    req_wen   = '0;
    ram_state = FREE;
    #1;
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL wr_idle_wen: got %0b want 0", ram_wen); end
  endtask

  task automatic test_error_retry;
    do_reset;
    req_addr[0 +: 32]  = 32'h700;
    req_addr[64 +: 32] = 32'h720;
    req_addr[96 +: 32] = 32'h730;
    req_ren[2]         = 1'b1;
    ram_state          = ACCESS;
    #1;
    next_cycle;
    checks++; if (ram_addr !== 32'h720) begin errors++; $display("[TB] FAIL er_setup: got %h want 720", ram_addr); end
    next_cycle;
    req_ren = 4'b1000;
    #1;
    next_cycle;
    ram_state = ERROR;
    req_ren   = 4'b1001;
    #1;
    checks++; if (ram_addr !== 32'h730) begin errors++; $display("[TB] FAIL er_grant3: got %h want 730", ram_addr); end
    checks++; if (req_wait !== 4'b1001) begin errors++; $display("[TB] FAIL er_wait: got %b want 1001", req_wait); end
    next_cycle;
    ram_state = FREE;
    #1;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL er_idle: got %0b want 0", ram_ren); end
    checks++; if (req_wait[3] !== 1'b1) begin errors++; $display("[TB] FAIL er_hold3: got %0b want 1", req_wait[3]); end
    next_cycle;
    checks++; if (ram_addr !== 32'h730) begin errors++; $display("[TB] FAIL er_retry: got %h want 730", ram_addr); end
    checks++; if (ram_ren !== 1'b1) begin errors++; $display("[TB] FAIL er_retry_ren: got %0b want 1", ram_ren); end
    req_ren = '0;
  endtask

  task automatic test_abort_and_reset;
    do_reset;
    req_addr[0 +: 32]  = 32'h300;
    req_addr[32 +: 32] = 32'h310;
    req_addr[64 +: 32] = 32'h320;
    req_ren            = 4'b0011;
    ram_state          = BUSY;
    #1;
    next_cycle;
    checks++; if (ram_addr !== 32'h300) begin errors++; $display("[TB] FAIL ab_grant0: got %h want 300", ram_addr); end
    next_cycle;
    req_ren[0] = 1'b0;
    #1;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL ab_strobe: got %0b want 0", ram_ren); end
    checks++; if (req_wait !== 4'b0010) begin errors++; $display("[TB] FAIL ab_wait: got %b want 0010", req_wait); end
    next_cycle;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL ab_idle: got %0b want 0", ram_ren); end
    next_cycle;
    checks++; if (ram_addr !== 32'h310) begin errors++; $display("[TB] FAIL ab_grant1: got %h want 310", ram_addr); end
    ram_state = ACCESS;
    #1;
    checks++; if (req_wait !== 4'b0000) begin errors++; $display("[TB] FAIL ab_done1: got %b want 0000", req_wait); end
    next_cycle;
    req_ren   = 4'b0101;
    ram_state = BUSY;
    #1;
    next_cycle;
    checks++; if (ram_addr !== 32'h320) begin errors++; $display("[TB] FAIL ab_grant2: got %h want 320", ram_addr); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL ab_rst_ren: got %0b want 0", ram_ren); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("[TB] FAIL ab_rst_addr: got %h want 0", ram_addr); end
    checks++; if (req_rdata !== 32'h0) begin errors++; $display("[TB] FAIL ab_rst_rdata: got %h want 0", req_rdata); end
    next_cycle;
    RST = 1'b0;
    #1;
    next_cycle;
    checks++; if (ram_addr !== 32'h300) begin errors++; $display("[TB] FAIL ab_rst_prio: got %h want 300", ram_addr); end
    req_ren = '0;
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock;
    do_reset;
    req_addr[32 +: 32] = 32'h400;
    req_addr[64 +: 32] = 32'h500;
    req_ren            = 4'b0110;
    req_lock           = 4'b0010;
    ram_state          = ACCESS;
    ram_rdata          = 32'hA5A5A5A5;
    #1;
    next_cycle;
    checks++; if (ram_addr !== 32'h400) begin errors++; $display("[TB] FAIL lk_first: got %h want 400", ram_addr); end
    checks++; if (req_wait !== 4'b0100) begin errors++; $display("[TB] FAIL lk_wait1: got %b want 0100", req_wait); end
    next_cycle;
    req_addr[32 +: 32] = 32'h404;
    req_lock           = 4'b0000;
    #1;
    checks++; if (ram_ren !== 1'b1) begin errors++; $display("[TB] FAIL lk_b2b_ren: got %0b want 1", ram_ren); end
    checks++; if (ram_addr !== 32'h404) begin errors++; $display("[TB] FAIL lk_b2b_addr: got %h want 404", ram_addr); end
    checks++; if (req_wait !== 4'b0100) begin errors++; $display("[TB] FAIL lk_wait2: got %b want 0100", req_wait); end
    next_cycle;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("[TB] FAIL lk_idle: got %0b want 0", ram_ren); end
    next_cycle;
    checks++; if (ram_addr !== 32'h500) begin errors++; $display("[TB] FAIL lk_next: got %h want 500", ram_addr); end
    req_ren = '0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_single_read;
    test_round_robin;
    test_write_wins;
    test_error_retry;
    test_abort_and_reset;
`ifdef ARB_LOCK_EN
    test_lock;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
